// File: rtl/serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// serial_frame_receiver
//   Bit-serial frame receiver. The line is oversampled at `rate` clocks per bit
//   and each bit is recovered by majority vote. The receiver hunts for a sync
//   word, reads a length header (payload bytes), then descrambles the payload
//   with an x^7+x^4+1 additive descrambler and streams it out one bit per
//   data_out_valid pulse.
//
// Ports
//   Clk             in   1  system clock, rising edge
//   reset           in   1  asynchronous, active-low reset
//   data_in         in   1  serial line sample, one per Clk
//   rate            in   4  samples per bit N (1..15); 0 holds the receiver idle
//   data_out        out  1  recovered, descrambled payload bit (registered)
//   data_out_valid  out  1  one-Clk pulse qualifying data_out (registered)
//
// Bit periods are aligned to reset release (or to the end of a rate=0 hold);
// there is no clock recovery or edge re-alignment.
// -----------------------------------------------------------------------------
module serial_frame_receiver #(
  parameter logic [15:0] SYNC_WORD = 16'hA5F0,
  parameter int unsigned LEN_W     = 12,
  parameter logic [6:0]  SCR_SEED  = 7'h7F
) (
  input  logic       Clk,
  input  logic       reset,
  input  logic       data_in,
  input  logic [3:0] rate,
  output logic       data_out,
  output logic       data_out_valid
);

  typedef enum logic [1:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD
  } state_t;

  // Payload bit counter must hold length*8.
  localparam int unsigned REM_W  = LEN_W + 3;
  localparam int unsigned BCNT_W = $clog2(LEN_W);

  // ---------------------------------------------------------------------------
  // Bit timing and majority vote
  // ---------------------------------------------------------------------------
  logic [3:0] r_sample_cnt;
  logic [3:0] r_rate_lat;
  logic [3:0] r_ones_cnt;

  logic [3:0] w_n;
  logic [3:0] w_ones_acc;
  logic       w_last;
  logic       w_bit;

  always_comb begin
    // At sample 0 the live rate input defines the period being started; later
    // samples use the value latched at sample 0, so a mid-bit change of rate
    // only affects the next bit.
    w_n        = (r_sample_cnt == 4'd0) ? rate : r_rate_lat;
    w_ones_acc = r_ones_cnt + {3'b000, data_in};
    w_last     = (rate != 4'd0) && (r_sample_cnt == (w_n - 4'd1));
    // Strict majority: ties on even N resolve to 0.
    w_bit      = ({w_ones_acc, 1'b0} > {1'b0, w_n});
  end

  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_sample_cnt <= 4'd0;
      r_rate_lat   <= 4'd0;
      r_ones_cnt   <= 4'd0;
    end else if (rate == 4'd0) begin
      // Idle hold: discard any partial bit so timing restarts cleanly.
      r_sample_cnt <= 4'd0;
      r_ones_cnt   <= 4'd0;
    end else begin
      if (r_sample_cnt == 4'd0) begin
        r_rate_lat <= rate;
      end
      if (w_last) begin
        r_sample_cnt <= 4'd0;
        r_ones_cnt   <= 4'd0;
      end else begin
        r_sample_cnt <= r_sample_cnt + 4'd1;
        r_ones_cnt   <= w_ones_acc;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Frame FSM, advanced once per decided bit
  // ---------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nxt;
  logic [15:0]        r_sreg;
  logic [15:0]        w_sreg_nxt;
  logic [LEN_W-1:0]   r_len_sreg;
  logic [LEN_W-1:0]   w_len_nxt;
  logic [LEN_W-1:0]   w_len_shift;
  logic [BCNT_W-1:0]  r_bit_cnt;
  logic [BCNT_W-1:0]  w_bcnt_nxt;
  logic [REM_W-1:0]   r_remaining;
  logic [REM_W-1:0]   w_rem_nxt;
  logic [6:0]         r_scr;
  logic [6:0]         w_scr_nxt;
  logic               w_fb;
  logic               r_data_out;
  logic               w_out_nxt;
  logic               r_data_out_valid;
  logic               w_valid_nxt;

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_HUNT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    w_state_nxt = r_state;
    w_sreg_nxt  = r_sreg;
    w_len_nxt   = r_len_sreg;
    w_bcnt_nxt  = r_bit_cnt;
    w_rem_nxt   = r_remaining;
    w_scr_nxt   = r_scr;
    w_out_nxt   = r_data_out;
    w_valid_nxt = 1'b0;
    w_fb        = r_scr[6] ^ r_scr[3];
    w_len_shift = {r_len_sreg[LEN_W-2:0], w_bit};

    if (w_last) begin
      unique case (r_state)
        ST_HUNT: begin
          // Sliding window; overlapping sync candidates are naturally found.
          w_sreg_nxt = {r_sreg[14:0], w_bit};
          if (w_sreg_nxt == SYNC_WORD) begin
            w_state_nxt = ST_LEN;
            w_bcnt_nxt  = '0;
          end
        end
        ST_LEN: begin
          w_len_nxt = w_len_shift;
          if (r_bit_cnt == BCNT_W'(LEN_W - 1)) begin
            if (w_len_shift == '0) begin
              w_state_nxt = ST_HUNT;
            end else begin
              w_state_nxt = ST_PAYLOAD;
              w_rem_nxt   = {w_len_shift, 3'b000};
              w_scr_nxt   = SCR_SEED;
            end
          end else begin
            w_bcnt_nxt = r_bit_cnt + BCNT_W'(1);
          end
        end
        ST_PAYLOAD: begin
          w_out_nxt   = w_bit ^ w_fb;
          w_valid_nxt = 1'b1;
          w_scr_nxt   = {r_scr[5:0], w_fb};
          w_rem_nxt   = r_remaining - REM_W'(1);
          if (r_remaining == REM_W'(1)) begin
            // Clearing the window forces a full fresh sync word next frame.
            w_state_nxt = ST_HUNT;
            w_sreg_nxt  = '0;
          end
        end
        default: begin
          w_state_nxt = ST_HUNT;
        end
      endcase
    end
  end

  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      r_sreg           <= '0;
      r_len_sreg       <= '0;
      r_bit_cnt        <= '0;
      r_remaining      <= '0;
      r_scr            <= SCR_SEED;
      r_data_out       <= 1'b0;
      r_data_out_valid <= 1'b0;
    end else begin
      r_sreg           <= w_sreg_nxt;
      r_len_sreg       <= w_len_nxt;
      r_bit_cnt        <= w_bcnt_nxt;
      r_remaining      <= w_rem_nxt;
      r_scr            <= w_scr_nxt;
      r_data_out       <= w_out_nxt;
      r_data_out_valid <= w_valid_nxt;
    end
  end

  assign data_out       = r_data_out;
  assign data_out_valid = r_data_out_valid;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// -----------------------------------------------------------------------------
// tb_serial_frame_receiver
//   Table-driven frame vectors, hand-written reset/hold sequences and random
//   frames, checked against a frame-level reference model that works on the
//   stream of majority-voted bits.
// -----------------------------------------------------------------------------
module tb_serial_frame_receiver;

  localparam logic [15:0] SYNC_WORD = 16'hA5F0;
  localparam int          LEN_W     = 12;
  localparam int          NV        = 10;

  logic       Clk     = 1'b0;
  logic       reset   = 1'b1;
  logic       data_in = 1'b0;
  logic [3:0] rate    = 4'd0;
  logic       data_out;
  logic       data_out_valid;

  serial_frame_receiver dut (
    .Clk            (Clk),
    .reset          (reset),
    .data_in        (data_in),
    .rate           (rate),
    .data_out       (data_out),
    .data_out_valid (data_out_valid)
  );

  always #5 Clk = ~Clk;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // Captured output pulses and the decided-bit stream since the last reset.
  bit cap_val[$];
  int cap_cyc[$];
  bit g_bits[$];
  int g_cyc[$];

  always @(negedge Clk) begin
    if (reset && data_out_valid) begin
      cap_val.push_back(data_out);
      cap_cyc.push_back(cyc);
    end
  end

  typedef struct {
    int         n;
    int         len;
    logic [7:0] payload;
    int         flip_bit;
    int         flip_cnt;
    int         exp_pulses;
    logic [7:0] exp_byte;
  } vec_t;

  vec_t vecs[NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives one bit period of n samples, the first `flips` inverted. When
  // new_rate >= 0 the rate input is changed after the first sample.
  task automatic send_bit(input bit b, input int n, input int flips, input int new_rate);
    int ones;
    ones = 0;
    for (int i = 0; i < n; i++) begin
      data_in = (i < flips) ? ~b : b;
      if (data_in) ones++;
      @(negedge Clk);
      if (i == 0 && new_rate >= 0) rate = 4'(new_rate);
    end
    g_bits.push_back(2 * ones > n);
    g_cyc.push_back(cyc);
  endtask

  task automatic send_word(input logic [31:0] v, input int w, input int n);
    for (int k = w - 1; k >= 0; k--) send_bit(v[k], n, 0, -1);
  endtask

  task automatic send_frame(input int n, input int len, input logic [7:0] pl,
                            input int flip_bit, input int flip_cnt);
    send_word(32'(SYNC_WORD), 16, n);
    send_word(32'(len), LEN_W, n);
    if (len > 0) begin
      for (int k = 0; k < 8; k++) send_bit(pl[7-k], n, (k == flip_bit) ? flip_cnt : 0, -1);
    end
    send_bit(1'b0, n, 0, -1);
  endtask

  function automatic int noise(input int n);
    return int'($urandom_range(0, (n - 1) / 2));
  endfunction

  // Frame-level reference: sliding sync search over the hunt history, length
  // header, then payload XOR the keystream x[j] = x[j-7] ^ x[j-4] seeded 1111111.
  function automatic void model(input bit bits[$], output bit ov[$], output int oi[$]);
    bit          hist[$];
    bit          ks[$];
    logic [15:0] w;
    int          i;
    int          len;
    ov.delete();
    oi.delete();
    for (int k = 0; k < 16; k++) hist.push_back(1'b0);
    i = 0;
    while (i < bits.size()) begin
      void'(hist.pop_front());
      hist.push_back(bits[i]);
      i++;
      w = '0;
      foreach (hist[k]) w = {w[14:0], hist[k]};
      if (w == SYNC_WORD) begin
        if (i + LEN_W > bits.size()) return;
        len = 0;
        for (int k = 0; k < LEN_W; k++) len = len * 2 + int'(bits[i+k]);
        i += LEN_W;
        if (len > 0) begin
          ks.delete();
          for (int k = 0; k < 7; k++) ks.push_back(1'b1);
          for (int p = 0; p < len * 8; p++) begin
            if (i >= bits.size()) return;
            ks.push_back(ks[p] ^ ks[p+3]);
            ov.push_back(bits[i] ^ ks[p+7]);
            oi.push_back(i);
            i++;
          end
          hist.delete();
          for (int k = 0; k < 16; k++) hist.push_back(1'b0);
        end
      end
    end
  endfunction

  task automatic check_model(input string tag);
    bit ev[$];
    int ei[$];
    model(g_bits, ev, ei);
    check($sformatf("%s pulse count", tag), cap_val.size(), ev.size());
    for (int k = 0; k < ev.size() && k < cap_val.size(); k++) begin
      check($sformatf("%s bit%0d", tag, k), 32'(cap_val[k]), 32'(ev[k]));
      check($sformatf("%s cyc%0d", tag, k), cap_cyc[k], g_cyc[ei[k]]);
    end
  endtask

  // Called at a falling edge; releases reset on a falling edge so the next
  // rising edge is sample 0.
  task automatic do_reset();
    reset = 1'b0;
    #1;
    check("reset data_out", 32'(data_out), 32'd0);
    check("reset valid", 32'(data_out_valid), 32'd0);
    repeat (2) @(negedge Clk);
    g_bits.delete();
    g_cyc.delete();
    cap_val.delete();
    cap_cyc.delete();
    reset = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: run exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int         base;
    int         n;
    int         nn;
    int         len;
    int         npre;
    int         flips;
    logic [7:0] got;

    vecs = '{
      '{9,  1, 8'h00, -1, 0, 8, 8'h0E},
      '{9,  1, 8'h00,  3, 4, 8, 8'h0E},
      '{9,  1, 8'h00,  3, 5, 8, 8'h1E},
      '{4,  0, 8'h00, -1, 0, 0, 8'h00},
      '{4,  1, 8'hFF, -1, 0, 8, 8'hF1},
      '{4,  1, 8'hFF,  0, 2, 8, 8'h71},
      '{1,  1, 8'hA5, -1, 0, 8, 8'hAB},
      '{15, 1, 8'h3C,  6, 7, 8, 8'h32},
      '{15, 1, 8'h3C,  7, 8, 8, 8'h33},
      '{2,  1, 8'h5A, -1, 0, 8, 8'h54}
    };

    @(negedge Clk);
    do_reset();

    // Table-driven frames.
    for (int v = 0; v < NV; v++) begin
      base = cap_val.size();
      rate = 4'(vecs[v].n);
      send_frame(vecs[v].n, vecs[v].len, vecs[v].payload, vecs[v].flip_bit, vecs[v].flip_cnt);
      check($sformatf("vec%0d pulses", v), cap_val.size() - base, vecs[v].exp_pulses);
      if (vecs[v].exp_pulses == 8 && cap_val.size() - base == 8) begin
        got = '0;
        for (int k = 0; k < 8; k++) got = {got[6:0], cap_val[base+k]};
        check($sformatf("vec%0d byte", v), 32'(got), 32'(vecs[v].exp_byte));
        for (int k = 1; k < 8; k++)
          check($sformatf("vec%0d spacing%0d", v, k),
                cap_cyc[base+k] - cap_cyc[base+k-1], vecs[v].n);
      end
    end
    check_model("table");

    // rate=0 hold mid-HUNT with a partial bit pending.
    rate = 4'd9;
    for (int k = 0; k < 5; k++) send_bit(1'($urandom), 9, 0, -1);
    data_in = 1'b1;
    repeat (4) @(negedge Clk);
    base = cap_val.size();
    rate = 4'd0;
    for (int k = 0; k < 50; k++) begin
      data_in = 1'($urandom);
      @(negedge Clk);
    end
    check("hold no pulses", cap_val.size(), base);
    rate = 4'd9;
    send_frame(9, 1, 8'($urandom), -1, 0);
    check_model("hold");

    // Reset asserted after three payload pulses.
    rate = 4'd6;
    send_word(32'(SYNC_WORD), 16, 6);
    send_word(32'd1, LEN_W, 6);
    for (int k = 0; k < 3; k++) send_bit(1'b1, 6, 0, -1);
    data_in = 1'b0;
    repeat (2) @(negedge Clk);
    check_model("pre-reset");
    check("data_out before reset", 32'(data_out), 32'd1);
    do_reset();
    rate = 4'd6;
    send_word(32'h10, 5, 6);
    for (int k = 0; k < 8; k++) send_bit(1'($urandom), 6, 0, -1);
    check("no pulses after reset", cap_val.size(), 0);
    send_frame(6, 1, 8'($urandom), -1, 0);
    check_model("post-reset");

    // Random frames: noisy samples, random prefixes, rate changed mid-bit.
    do_reset();
    n = int'($urandom_range(1, 15));
    rate = 4'(n);
    for (int f = 0; f < 6; f++) begin
      npre = int'($urandom_range(0, 20));
      len  = int'($urandom_range(1, 3));
      for (int k = 0; k < npre; k++) send_bit(1'($urandom), n, int'($urandom_range(0, n)), -1);
      for (int k = 15; k >= 0; k--) send_bit(SYNC_WORD[k], n, noise(n), -1);
      for (int k = LEN_W - 1; k >= 0; k--) send_bit(((len >> k) & 1) != 0, n, noise(n), -1);
      for (int k = 0; k < len * 8; k++) begin
        flips = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, n)) : noise(n);
        send_bit(1'($urandom), n, flips, -1);
      end
      nn = int'($urandom_range(1, 15));
      send_bit(1'b0, n, 0, nn);
      n = nn;
    end
    send_bit(1'b0, n, 0, -1);
    check_model("random");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
